// File: rtl/fsm_vedacao.sv
// Cork-capper sequencer: seals one bottle per command and tracks the cork stock.
// Optional low-stock warning is enabled by defining the macro ROLHA_AVISO_EN.
module fsm_vedacao #(
  parameter int unsigned TEMPO_VEDACAO   = 25000000,
  parameter int unsigned ESTOQUE_INICIAL = 20,
  parameter int unsigned REPOSICAO       = 15,
  parameter int unsigned MAX_ROLHAS      = 99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_vedar,
  input  logic       repor_rolhas,
  output logic       vedacao_concluida,
  output logic       alarme_rolha,
  output logic       atuador_vedacao,
  output logic [6:0] rolhas_restantes,
  output logic       aviso_rolha_baixa
);

  typedef enum logic [2:0] {
    IDLE              = 3'd0,
    VEDANDO           = 3'd1,
    CONCLUIDO         = 3'd2,
    AGUARDA_LIBERACAO = 3'd3,
    SEM_ROLHA         = 3'd4
  } state_t;

  localparam logic [25:0] TEMPO_LAST = 26'(TEMPO_VEDACAO - 1);
  localparam logic [7:0]  MAX8       = 8'(MAX_ROLHAS);
  localparam logic [7:0]  REP8       = 8'((REPOSICAO > MAX_ROLHAS) ? MAX_ROLHAS : REPOSICAO);
  localparam logic [6:0]  INIT7      = 7'((ESTOQUE_INICIAL > MAX_ROLHAS) ? MAX_ROLHAS : ESTOQUE_INICIAL);

  state_t      state, state_nxt;
  logic [25:0] timer, timer_nxt;
  logic [6:0]  count_nxt;
  logic [7:0]  sum;
  logic        dec;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    dec       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_vedar) begin
          if (rolhas_restantes != 7'd0) begin
            state_nxt = VEDANDO;
            timer_nxt = '0;
          end else begin
            state_nxt = SEM_ROLHA;
          end
        end
      end
      VEDANDO: begin
        // Dropping the command aborts the seal; the cork is not consumed.
        if (!cmd_vedar) begin
          state_nxt = IDLE;
        end else if (timer == TEMPO_LAST) begin
          state_nxt = CONCLUIDO;
          dec       = 1'b1;
        end else begin
          timer_nxt = timer + 26'd1;
        end
      end
      CONCLUIDO:         state_nxt = AGUARDA_LIBERACAO;
      AGUARDA_LIBERACAO: if (!cmd_vedar) state_nxt = IDLE;
      SEM_ROLHA:         if (!cmd_vedar) state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase

    // Decrement first, then refill, then clamp: gives min(count-1+REPOSICAO, MAX).
    sum = {1'b0, rolhas_restantes} - {7'd0, dec && (rolhas_restantes != 7'd0)};
    if (repor_rolhas) sum = sum + REP8;
    if (sum > MAX8) sum = MAX8;
    count_nxt = sum[6:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      timer             <= '0;
      rolhas_restantes  <= INIT7;
      alarme_rolha      <= (INIT7 == 7'd0);
      atuador_vedacao   <= 1'b0;
      vedacao_concluida <= 1'b0;
    end else begin
      state             <= state_nxt;
      timer             <= timer_nxt;
      rolhas_restantes  <= count_nxt;
      alarme_rolha      <= (count_nxt == 7'd0);
      atuador_vedacao   <= (state_nxt == VEDANDO);
      vedacao_concluida <= (state_nxt == CONCLUIDO);
    end
  end

`ifdef ROLHA_AVISO_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) aviso_rolha_baixa <= 1'b0;
    else          aviso_rolha_baixa <= (count_nxt >= 7'd1) && (count_nxt <= 7'd5);
  end
`else
  assign aviso_rolha_baixa = 1'b0;
`endif

endmodule
